pc_alu_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 27 ++
 rtl/pc_alu_unit_add32.sv | 13 +
 rtl/pc_alu_unit_alu32.sv | 39 +++
 rtl/pc_alu_unit.sv | 80 ++++++++
 tb/tb_pc_alu_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared opcode and next-PC encodings for the PC/ALU datapath.
// Pure declarations: no latency or flow control of its own.
package mips_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_SLT  = 3'b100,
        ALU_SLTU = 3'b101,
        ALU_NOR  = 3'b110,
        ALU_XOR  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_SRC_PC4    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2,
        PC_SRC_JR     = 2'd3
    } pc_src_t;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam int JUMP_IDX_W = 26;

endpackage

// File: rtl/pc_alu_unit_add32.sv
// Modulo-2^WIDTH adder, combinational; carry-out is dropped on purpose.
// No state, no flow control.
module add32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/pc_alu_unit_alu32.sv
// Execute-stage ALU with zero flag, combinational (zero-cycle latency).
// No overflow trap; no flow control.
module alu32
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_t          op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    logic slt_lt;
    logic sltu_lt;

    assign slt_lt  = $signed(a_i) < $signed(b_i);
    assign sltu_lt = a_i < b_i;

    always_comb begin
        result_o = '0;
        unique case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, slt_lt};
            ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, sltu_lt};
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_XOR:  result_o = a_i ^ b_i;
            default:  result_o = '0;
        endcase
    end

    // Flag follows the result for every opcode, including SLT/SLTU.
    assign zero_o = (result_o == '0);

endmodule

// File: rtl/pc_alu_unit.sv
// PC register, PC+4/branch adders, next-PC mux and execute ALU; PC updates one edge after selection.
// pc_load=0 stalls the PC (any pc_src that cycle is dropped); everything else is combinational.
module pc_alu_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_load,
    input  logic [1:0]            pc_src,
    input  logic [WIDTH-1:0]      id_pc4,
    input  logic [WIDTH-1:0]      imm_sext,
    input  logic [JUMP_IDX_W-1:0] jump_index,
    input  logic [WIDTH-1:0]      jr_addr,
    input  logic [WIDTH-1:0]      alu_a,
    input  logic [WIDTH-1:0]      alu_b,
    input  logic [2:0]            alu_ctrl,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      pc_plus4,
    output logic [WIDTH-1:0]      branch_target,
    output logic [WIDTH-1:0]      alu_result,
    output logic                  alu_zero
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] imm_shifted;
    logic [WIDTH-1:0] jump_target;
    pc_src_t          pc_sel;

    assign imm_shifted = {imm_sext[WIDTH-3:0], 2'b00};
    // Jump keeps the 256 MB region of the decode instruction's PC+4.
    assign jump_target = {id_pc4[WIDTH-1:JUMP_IDX_W+2], jump_index, 2'b00};
    assign pc_sel      = pc_src_t'(pc_src);

    add32 #(.WIDTH(WIDTH)) u_pc_inc (
        .a_i   (pc_q),
        .b_i   (PC_STEP),
        .sum_o (pc_plus4)
    );

    add32 #(.WIDTH(WIDTH)) u_br_add (
        .a_i   (id_pc4),
        .b_i   (imm_shifted),
        .sum_o (branch_target)
    );

    always_comb begin
        pc_d = pc_plus4;
        unique case (pc_sel)
            PC_SRC_PC4:    pc_d = pc_plus4;
            PC_SRC_BRANCH: pc_d = branch_target;
            PC_SRC_JUMP:   pc_d = jump_target;
            PC_SRC_JR:     pc_d = jr_addr;
            default:       pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= WIDTH'(RESET_PC);
        end else if (pc_load) begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

    alu32 #(.WIDTH(WIDTH)) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .op_i     (alu_op_t'(alu_ctrl)),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

endmodule

// File: tb/tb_pc_alu_unit.sv
// Bench for pc_alu_unit: spec-level model checked every negedge plus directed literal checks.
module tb_pc_alu_unit;

    logic        clk;
    logic        rst;
    logic        pc_load;
    logic [1:0]  pc_src;
    logic [31:0] id_pc4;
    logic [31:0] imm_sext;
    logic [25:0] jump_index;
    logic [31:0] jr_addr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] alu_result;
    logic        alu_zero;

    int total;
    int passed;
    logic [31:0] mpc;
    bit done;

    pc_alu_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_load       (pc_load),
        .pc_src        (pc_src),
        .id_pc4        (id_pc4),
        .imm_sext      (imm_sext),
        .jump_index    (jump_index),
        .jr_addr       (jr_addr),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_ctrl      (alu_ctrl),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5: return (a < b) ? 32'd1 : 32'd0;
            3'd6: return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] cur);
        case (pc_src)
            2'd0: return cur + 32'd4;
            2'd1: return id_pc4 + imm_sext * 32'd4;
            2'd2: return (id_pc4 & 32'hF000_0000) | ({6'd0, jump_index} * 32'd4);
            default: return jr_addr;
        endcase
    endfunction

    // Model of the PC as the specification states it.
    always @(posedge clk or posedge rst) begin
        if (rst) mpc = 32'h0;
        else if (pc_load) mpc = model_next(mpc);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!done) begin
            logic [31:0] er;
            er = model_alu(alu_ctrl, alu_a, alu_b);
            check("model_pc", pc, mpc);
            check("model_pc_plus4", pc_plus4, mpc + 32'd4);
            check("model_branch_target", branch_target, id_pc4 + imm_sext * 32'd4);
            check("model_alu_result", alu_result, er);
            check("model_alu_zero", {31'd0, alu_zero}, (er == 32'd0) ? 32'd1 : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        total = 0; passed = 0; done = 1'b0;
        rst = 1'b1; pc_load = 1'b0; pc_src = 2'd0;
        id_pc4 = 32'h0; imm_sext = 32'h0; jump_index = 26'h0; jr_addr = 32'h0;
        alu_a = 32'h0; alu_b = 32'h0; alu_ctrl = 3'd0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_pc", pc, 32'h0);
        check("reset_pc_plus4", pc_plus4, 32'h4);

        rst = 1'b0; pc_load = 1'b1; pc_src = 2'd0;
        step(); check("inc_1", pc, 32'h4);
        step(); check("inc_2", pc, 32'h8);
        step(); check("inc_3", pc, 32'hC);

        // Asynchronous reset between edges.
        rst = 1'b1;
        #1;
        check("async_reset_pc", pc, 32'h0);
        check("async_reset_pc4", pc_plus4, 32'h4);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step();
        check("pc_0x10", pc, 32'h10);

        // Stall with a branch selected: stall wins.
        pc_load = 1'b0; pc_src = 2'd1; id_pc4 = 32'h20; imm_sext = 32'hFFFF_FFFE;
        #1;
        check("branch_target_lit", branch_target, 32'h18);
        step(); check("stall_1", pc, 32'h10);
        step(); check("stall_2", pc, 32'h10);

        pc_load = 1'b1;
        step(); check("branch_taken", pc, 32'h18);

        pc_src = 2'd2; id_pc4 = 32'h4000_0008; jump_index = 26'h000_0010;
        step(); check("jump", pc, 32'h4000_0040);

        pc_src = 2'd3; jr_addr = 32'h0000_1234;
        step(); check("jr", pc, 32'h0000_1234);

        // Stall again under a jump select.
        pc_load = 1'b0; pc_src = 2'd2;
        step(); check("stall_jump", pc, 32'h0000_1234);
        pc_load = 1'b1;

        jr_addr = 32'hFFFF_FFFC; pc_src = 2'd3;
        step(); check("pc_top", pc, 32'hFFFF_FFFC);
        check("pc4_wrap", pc_plus4, 32'h0);
        pc_src = 2'd0;
        step(); check("pc_wrap", pc, 32'h0);

        alu_ctrl = 3'd0; alu_a = 32'hFFFF_FFFF; alu_b = 32'h1;
        #1; check("add_wrap", alu_result, 32'h0); check("add_zero", {31'd0, alu_zero}, 32'd1);
        alu_ctrl = 3'd1; alu_a = 32'd5; alu_b = 32'd7;
        #1; check("sub", alu_result, 32'hFFFF_FFFE); check("sub_zero", {31'd0, alu_zero}, 32'd0);
        alu_ctrl = 3'd4; alu_a = 32'hFFFF_FFFF; alu_b = 32'd1;
        #1; check("slt", alu_result, 32'd1);
        alu_ctrl = 3'd5;
        #1; check("sltu", alu_result, 32'd0); check("sltu_zero", {31'd0, alu_zero}, 32'd1);
        alu_a = 32'hF0F0_F0F0; alu_b = 32'hFF00_FF00;
        alu_ctrl = 3'd2; #1; check("and", alu_result, 32'hF000_F000);
        alu_ctrl = 3'd3; #1; check("or",  alu_result, 32'hFFF0_FFF0);
        alu_ctrl = 3'd6; #1; check("nor", alu_result, 32'h000F_000F);
        alu_ctrl = 3'd7; #1; check("xor", alu_result, 32'h0FF0_0FF0);

        // Sweep every opcode over a few operand pairs for the model compare.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk); #1;
                alu_ctrl = i[2:0];
                case (j)
                    0: begin alu_a = 32'h8000_0000; alu_b = 32'h7FFF_FFFF; end
                    1: begin alu_a = 32'h1234_5678; alu_b = 32'h1234_5678; end
                    default: begin alu_a = 32'h0000_0003; alu_b = 32'hFFFF_FFFD; end
                endcase
            end
        end
        @(negedge clk); #1;
        alu_ctrl = 3'd1; alu_a = 32'h1234_5678; alu_b = 32'h1234_5678;
        #1; check("sub_equal_zero", {31'd0, alu_zero}, 32'd1);
        alu_ctrl = 3'd4; alu_a = 32'h8000_0000; alu_b = 32'h7FFF_FFFF;
        #1; check("slt_minint", alu_result, 32'd1);
        alu_ctrl = 3'd5;
        #1; check("sltu_minint", alu_result, 32'd0);

        @(negedge clk);
        done = 1'b1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
